// File: rtl/request_tracker.sv
// request_tracker
//   Floor-request tracker for the elevator controller. Keeps a per-floor
//   bitmap of pending calls. A call is set by a request strobe and cleared
//   when the car services that floor. From the bitmap and the car position
//   it derives summary outputs and a direction-aware next target.
//
// Optional feature (compile-time macro REQ_CANCEL_EN):
//   Adds cancel_valid/cancel_floor. A cancel clears a pending floor. It has
//   lower priority than a service and higher priority than a request.
//
// Ports
//   clk, reset              rising-edge clock, async active-high reset
//   req_valid/req_floor     call request strobe and floor
//   svc_valid/svc_floor     service strobe (doors open) and floor
//   cancel_valid/_floor     cancel strobe and floor (REQ_CANCEL_EN only)
//   current_floor, dir_up   car position and travel bias from the motion FSM
//   requests, pending_cnt   pending bitmap and its popcount
//   any_req                 at least one floor pending
//   max_request/min_request highest/lowest pending floor (0 / NUM_FLOORS-1 when empty)
//   above_req/below_req     a pending floor exists above/below current_floor
//   next_target/next_valid  floor to head to next, and whether it is meaningful
//   req_err                 registered one-cycle pulse for an out-of-range floor on any strobe

module request_tracker #(
    parameter int unsigned  NUM_FLOORS = 8,
    localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
    localparam int unsigned CNT_W      = $clog2(NUM_FLOORS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic                  svc_valid,
    input  logic [FLOOR_W-1:0]    svc_floor,
`ifdef REQ_CANCEL_EN
    input  logic                  cancel_valid,
    input  logic [FLOOR_W-1:0]    cancel_floor,
`endif
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic [NUM_FLOORS-1:0] requests,
    output logic [CNT_W-1:0]      pending_cnt,
    output logic                  any_req,
    output logic [FLOOR_W-1:0]    max_request,
    output logic [FLOOR_W-1:0]    min_request,
    output logic                  above_req,
    output logic                  below_req,
    output logic [FLOOR_W-1:0]    next_target,
    output logic                  next_valid,
    output logic                  req_err
);

    // One-hot decode limited to real floors. An out-of-range index decodes
    // to all zeros, so it can never touch the bitmap. This also avoids a
    // constant compare when NUM_FLOORS is a power of two.
    function automatic logic [NUM_FLOORS-1:0] decode(input logic [FLOOR_W-1:0] floor);
        logic [NUM_FLOORS-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            d[i] = (floor == FLOOR_W'(i));
        end
        return d;
    endfunction

    logic [NUM_FLOORS-1:0] requests_q, requests_d;
    logic                  req_err_q, req_err_d;

    logic [NUM_FLOORS-1:0] req_dec, svc_dec, cancel_dec;
    logic [NUM_FLOORS-1:0] set_mask, clr_mask;
    logic                  bad_floor;

    always_comb begin
        req_dec = decode(req_floor);
        svc_dec = decode(svc_floor);
`ifdef REQ_CANCEL_EN
        cancel_dec = decode(cancel_floor);
        clr_mask   = (svc_valid ? svc_dec : '0) | (cancel_valid ? cancel_dec : '0);
        bad_floor  = (req_valid && req_dec == '0) || (svc_valid && svc_dec == '0) ||
                     (cancel_valid && cancel_dec == '0);
`else
        cancel_dec = '0;
        clr_mask   = svc_valid ? svc_dec : '0;
        bad_floor  = (req_valid && req_dec == '0) || (svc_valid && svc_dec == '0);
`endif
        set_mask = req_valid ? req_dec : '0;
        // Clears are applied after the set, so a clear on the same floor wins.
        requests_d = (requests_q | set_mask) & ~clr_mask;
        req_err_d  = bad_floor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            requests_q <= '0;
            req_err_q  <= 1'b0;
        end else begin
            requests_q <= requests_d;
            req_err_q  <= req_err_d;
        end
    end

    // Summary outputs: combinational on the bitmap and the car position.
    logic [CNT_W-1:0]   cnt;
    logic [FLOOR_W-1:0] max_r, min_r, low_above, high_below;
    logic               has_above, has_below, at_current;

    always_comb begin
        cnt        = '0;
        max_r      = '0;
        min_r      = FLOOR_W'(NUM_FLOORS - 1);
        low_above  = '0;
        high_below = '0;
        has_above  = 1'b0;
        has_below  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (requests_q[i]) begin
                cnt   = cnt + CNT_W'(1);
                max_r = FLOOR_W'(i);
                if (FLOOR_W'(i) > current_floor && !has_above) begin
                    low_above = FLOOR_W'(i);
                    has_above = 1'b1;
                end
                if (FLOOR_W'(i) < current_floor) begin
                    high_below = FLOOR_W'(i);
                    has_below  = 1'b1;
                end
            end
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (requests_q[i]) begin
                min_r = FLOOR_W'(i);
            end
        end
        at_current = |(requests_q & decode(current_floor));
    end

    always_comb begin
        next_target = current_floor;
        next_valid  = 1'b0;
        if (at_current) begin
            next_target = current_floor;
            next_valid  = 1'b1;
        end else if (dir_up) begin
            // Keep going up if possible, otherwise reverse.
            if (has_above) begin
                next_target = low_above;
                next_valid  = 1'b1;
            end else if (has_below) begin
                next_target = high_below;
                next_valid  = 1'b1;
            end
        end else begin
            if (has_below) begin
                next_target = high_below;
                next_valid  = 1'b1;
            end else if (has_above) begin
                next_target = low_above;
                next_valid  = 1'b1;
            end
        end
    end

    assign requests    = requests_q;
    assign pending_cnt = cnt;
    assign any_req     = |requests_q;
    assign max_request = max_r;
    assign min_request = min_r;
    assign above_req   = has_above;
    assign below_req   = has_below;
    assign req_err     = req_err_q;

endmodule

// File: tb/tb_request_tracker.sv
// Scoreboard bench for request_tracker.
// Two instances (8 and 6 floors) share one stimulus stream. A driver pushes
// the expected response per cycle into a queue, and a monitor pops it and
// compares it against the instance.

module tb_request_tracker;

`ifdef REQ_CANCEL_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    typedef struct {
        int requests; int cnt; int any; int maxr; int minr;
        int above; int below; int nt; int nv; int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0, svc_valid = 1'b0, cancel_valid = 1'b0, dir_up = 1'b1;
    logic [2:0] req_floor = '0, svc_floor = '0, cancel_floor = '0, current_floor = '0;

    logic [7:0] requests8;
    logic [3:0] cnt8;
    logic [2:0] max8, min8, nt8;
    logic       any8, above8, below8, nv8, err8;
    logic [5:0] requests6;
    logic [2:0] cnt6, max6, min6, nt6;
    logic       any6, above6, below6, nv6, err6;

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];
    bit   pend[2][8];
    int   model_err[2];
    int   cur_m = 0;
    bit   up_m  = 1'b1;

    always #5 clk = ~clk;

    request_tracker #(.NUM_FLOORS(8)) dut8 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_floor(req_floor),
        .svc_valid(svc_valid), .svc_floor(svc_floor),
`ifdef REQ_CANCEL_EN
        .cancel_valid(cancel_valid), .cancel_floor(cancel_floor),
`endif
        .current_floor(current_floor), .dir_up(dir_up),
        .requests(requests8), .pending_cnt(cnt8), .any_req(any8),
        .max_request(max8), .min_request(min8), .above_req(above8), .below_req(below8),
        .next_target(nt8), .next_valid(nv8), .req_err(err8)
    );

    request_tracker #(.NUM_FLOORS(6)) dut6 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_floor(req_floor),
        .svc_valid(svc_valid), .svc_floor(svc_floor),
`ifdef REQ_CANCEL_EN
        .cancel_valid(cancel_valid), .cancel_floor(cancel_floor),
`endif
        .current_floor(current_floor), .dir_up(dir_up),
        .requests(requests6), .pending_cnt(cnt6), .any_req(any6),
        .max_request(max6), .min_request(min6), .above_req(above6), .below_req(below6),
        .next_target(nt6), .next_valid(nv6), .req_err(err6)
    );

    function automatic int nf(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    // Reference model: walks the pending set and applies the selection rules.
    function automatic exp_t expect_of(input int d, input int cur, input bit up);
        exp_t e;
        int   n = nf(d);
        int   low_above = -1;
        int   high_below = -1;
        e = '{default: 0};
        e.minr = n - 1;
        for (int i = 0; i < n; i++) begin
            if (pend[d][i]) begin
                e.requests = e.requests + (1 << i);
                e.cnt++;
                if (e.cnt == 1) e.minr = i;
                e.maxr = i;
                if (i > cur && low_above < 0) low_above = i;
                if (i < cur) high_below = i;
            end
        end
        e.any   = (e.cnt > 0) ? 1 : 0;
        e.above = (low_above >= 0) ? 1 : 0;
        e.below = (high_below >= 0) ? 1 : 0;
        e.nt = cur;
        e.nv = 1;
        if (cur < n && pend[d][cur]) e.nt = cur;
        else if (up && low_above >= 0) e.nt = low_above;
        else if (high_below >= 0) e.nt = high_below;
        else if (low_above >= 0) e.nt = low_above;
        else e.nv = 0;
        e.err = model_err[d];
        return e;
    endfunction

    function automatic exp_t actual_of(input int d);
        exp_t a;
        if (d == 0) begin
            a = '{int'(requests8), int'(cnt8), int'(any8), int'(max8), int'(min8),
                  int'(above8), int'(below8), int'(nt8), int'(nv8), int'(err8)};
        end else begin
            a = '{int'(requests6), int'(cnt6), int'(any6), int'(max6), int'(min6),
                  int'(above6), int'(below6), int'(nt6), int'(nv6), int'(err6)};
        end
        return a;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t a, input exp_t e);
        check_int({tag, ".requests"}, a.requests, e.requests);
        check_int({tag, ".pending_cnt"}, a.cnt, e.cnt);
        check_int({tag, ".any_req"}, a.any, e.any);
        check_int({tag, ".max_request"}, a.maxr, e.maxr);
        check_int({tag, ".min_request"}, a.minr, e.minr);
        check_int({tag, ".above_req"}, a.above, e.above);
        check_int({tag, ".below_req"}, a.below, e.below);
        check_int({tag, ".next_target"}, a.nt, e.nt);
        check_int({tag, ".next_valid"}, a.nv, e.nv);
        check_int({tag, ".req_err"}, a.err, e.err);
    endtask

    // Monitor: compares one expected response per instance after each edge.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = actual_of(0);
                compare("dut8", a, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = actual_of(1);
                compare("dut6", a, e);
            end
        end
    end

    // One clock of stimulus; returns right after the active edge.
    task automatic cycle(input bit rv, input int rf, input bit sv, input int sf,
                         input int cur, input bit up, input bit cv, input int cf);
        bit cv_eff;
        @(negedge clk);
        cv_eff        = cv && CANCEL_EN;
        req_valid     = rv;
        req_floor     = 3'(rf);
        svc_valid     = sv;
        svc_floor     = 3'(sf);
        cancel_valid  = cv_eff;
        cancel_floor  = 3'(cf);
        current_floor = 3'(cur);
        dir_up        = up;
        cur_m         = cur;
        up_m          = up;
        for (int d = 0; d < 2; d++) begin
            int n = nf(d);
            model_err[d] = ((rv && rf >= n) || (sv && sf >= n) || (cv_eff && cf >= n)) ? 1 : 0;
            if (rv && rf < n) pend[d][rf] = 1'b1;
            if (cv_eff && cf < n) pend[d][cf] = 1'b0;
            if (sv && sf < n) pend[d][sf] = 1'b0;
        end
        @(posedge clk);
        q0.push_back(expect_of(0, cur, up));
        q1.push_back(expect_of(1, cur, up));
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            model_err[d] = 0;
            for (int i = 0; i < 8; i++) pend[d][i] = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e, a;
        for (int d = 0; d < 2; d++) begin
            e = expect_of(d, cur_m, up_m);
            a = actual_of(d);
            compare({tag, (d == 0) ? "8" : "6"}, a, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0; svc_valid = 1'b0; cancel_valid = 1'b0;
        clear_model();
        #1 check_reset_state("reset_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int rf, sf, cf, cur;
        bit rv, sv, cv, up;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_state("reset_init");
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 1, 0, 0);

        // Requests on 5 and 2.
        cycle(1, 5, 0, 0, 0, 1, 0, 0);
        cycle(1, 2, 0, 0, 0, 1, 0, 0);
        #1;
        check_int("t1.requests", int'(requests8), 'h24);
        check_int("t1.max", int'(max8), 5);
        check_int("t1.min", int'(min8), 2);

        // Pending {1,6}, car at 3: target follows direction.
        cycle(1, 1, 1, 5, 3, 1, 0, 0);
        cycle(1, 6, 1, 2, 3, 1, 0, 0);
        #1 check_int("t2.up_target", int'(nt8), 6);
        cycle(0, 0, 0, 0, 3, 0, 0, 0);
        #1 check_int("t2.down_target", int'(nt8), 1);

        // Same-cycle request and service on floor 4: service wins.
        cycle(1, 4, 1, 1, 3, 0, 0, 0);
        cycle(0, 0, 1, 6, 3, 0, 0, 0);
        cycle(1, 4, 1, 4, 3, 0, 0, 0);
        #1;
        check_int("t3.requests", int'(requests8), 0);
        check_int("t3.min_empty", int'(min8), 7);
        check_int("t3.next_valid", int'(nv8), 0);

        // Reversal with only floor 0 pending, then a call at the current floor.
        cycle(1, 0, 0, 0, 2, 1, 0, 0);
        #1 check_int("t4.reversal", int'(nt8), 0);
        cycle(1, 2, 0, 0, 2, 1, 0, 0);
        #1 check_int("t4.at_current", int'(nt8), 2);

        // Out-of-range floor on the 6-floor instance.
        cycle(1, 7, 0, 0, 2, 1, 0, 0);
        #1;
        check_int("t5.err_pulse", int'(err6), 1);
        check_int("t5.requests6", int'(requests6), 'h05);
        cycle(0, 0, 0, 0, 2, 1, 0, 0);
        #1 check_int("t5.err_clear", int'(err6), 0);

        // Build {1,3}, leave an error pulse pending, then reset mid-cycle.
        cycle(1, 1, 1, 0, 2, 1, 0, 0);
        cycle(1, 3, 1, 2, 2, 1, 0, 0);
        cycle(0, 0, 1, 7, 2, 1, 0, 0);
        #2 reset = 1'b1;
        req_valid = 1'b0; svc_valid = 1'b0; cancel_valid = 1'b0;
        clear_model();
        #1 check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 0, 0, 0, 2, 1, 0, 0);

`ifdef REQ_CANCEL_EN
        // Cancel beats a same-cycle request on the same floor.
        cycle(1, 3, 0, 0, 0, 1, 0, 0);
        cycle(1, 5, 0, 0, 0, 1, 0, 0);
        cycle(1, 5, 0, 0, 0, 1, 1, 5);
        #1;
        check_int("t6.requests", int'(requests8), 'h08);
        check_int("t6.max", int'(max8), 3);
        check_int("t6.cnt", int'(cnt8), 1);
`endif

        // Randomized traffic.
        cur = 0;
        up  = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            rf = $urandom_range(0, 7);
            sf = ($urandom_range(0, 3) == 0) ? rf : $urandom_range(0, 7);
            cf = ($urandom_range(0, 3) == 0) ? rf : $urandom_range(0, 7);
            rv = ($urandom_range(0, 1) == 1);
            sv = ($urandom_range(0, 2) == 0);
            cv = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) up = ~up;
            cycle(rv, rf, sv, sf, cur, up, cv, cf);
        end

        cycle(0, 0, 0, 0, cur, up, 0, 0);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
